// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg
//   Shared definitions for the ALU built-in self-test path: the run-state
//   encoding, the MISR width and the default MISR polynomial/seed. Imported by
//   the response monitor and by the stimulus sequencer's signature model.
package alu_bist_pkg;

    localparam int unsigned MISR_WIDTH = 32;

    localparam logic [MISR_WIDTH-1:0] DEFAULT_POLY = 32'h04C1_1DB7;
    localparam logic [MISR_WIDTH-1:0] DEFAULT_SEED = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

endpackage

// File: rtl/misr32.sv
// misr32
//   Combinational next-state function of a 32-bit multiple-input signature
//   register: shift left, fold the polynomial in when the MSB falls out, then
//   XOR the parallel data word and the injected bit 31.
//
// Ports
//   sig       in  32  current signature
//   data      in  32  parallel data word compacted this step
//   inject    in  1   extra bit XORed into bit 31
//   poly      in  32  feedback polynomial
//   next_sig  out 32  signature after this step
module misr32
    import alu_bist_pkg::*;
(
    input  logic [MISR_WIDTH-1:0] sig,
    input  logic [MISR_WIDTH-1:0] data,
    input  logic                  inject,
    input  logic [MISR_WIDTH-1:0] poly,
    output logic [MISR_WIDTH-1:0] next_sig
);

    always_comb begin
        next_sig = {sig[MISR_WIDTH-2:0], 1'b0}
                 ^ (sig[MISR_WIDTH-1] ? poly : '0)
                 ^ data
                 ^ {inject, {(MISR_WIDTH-1){1'b0}}};
    end

endmodule

// File: rtl/alu_response_monitor.sv
// alu_response_monitor
//   Compacts a run of ALU results (ALUOut, Branch_Enable) into a MISR
//   signature, counts samples, and on the final sample compares the signature
//   with golden_sig. A run also ends early if sample_valid stays low for
//   TIMEOUT consecutive cycles.
//
// Ports
//   clk            in  1   rising-edge clock
//   reset          in  1   synchronous active-high reset
//   start          in  1   begin (or restart) a run
//   sample_valid   in  1   ALUOut/Branch_Enable valid this cycle
//   ALUOut         in  32  ALU result
//   Branch_Enable  in  1   ALU branch decision
//   golden_sig     in  32  expected signature, sampled on the final sample
//   signature      out 32  current MISR value
//   sample_count   out 16  samples captured this run
//   busy           out 1   run in progress
//   done           out 1   run finished
//   pass           out 1   signature matched (valid while done)
//   timeout        out 1   run aborted by stall (valid while done)
module alu_response_monitor
    import alu_bist_pkg::*;
#(
    parameter int unsigned              NUM_SAMPLES = 16,
    parameter int unsigned              TIMEOUT     = 1024,
    parameter logic [MISR_WIDTH-1:0]    POLY        = DEFAULT_POLY,
    parameter logic [MISR_WIDTH-1:0]    SEED        = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sample_valid,
    input  logic [MISR_WIDTH-1:0] ALUOut,
    input  logic                  Branch_Enable,
    input  logic [MISR_WIDTH-1:0] golden_sig,
    output logic [MISR_WIDTH-1:0] signature,
    output logic [15:0]           sample_count,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout
);

    localparam logic [15:0] LAST_SAMPLE = 16'(NUM_SAMPLES - 1);
    localparam logic [15:0] LAST_STALL  = 16'(TIMEOUT - 1);

    bist_state_t             state;
    logic [15:0]             stall_count;
    logic [MISR_WIDTH-1:0]   next_sig;

    misr32 u_misr (
        .sig      (signature),
        .data     (ALUOut),
        .inject   (Branch_Enable),
        .poly     (POLY),
        .next_sig (next_sig)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            signature    <= SEED;
            sample_count <= '0;
            stall_count  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RUN;
                        signature    <= SEED;
                        sample_count <= '0;
                        stall_count  <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end

                RUN: begin
                    if (start) begin
                        // Restart takes priority; a coincident sample is dropped.
                        signature    <= SEED;
                        sample_count <= '0;
                        stall_count  <= '0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                    end else if (sample_valid) begin
                        signature    <= next_sig;
                        sample_count <= sample_count + 16'd1;
                        stall_count  <= '0;
                        if (sample_count == LAST_SAMPLE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (next_sig == golden_sig);
                        end
                    end else if (stall_count == LAST_STALL) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        stall_count <= stall_count + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
